dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester access controller for the 256-byte data memory. Sequences one 64-bit load or store at a time and shares the memory between port 0 (CPU load/store unit) and port 1 (debug/DMA loader). Drives the memory's `adr`, `datain`, `w` and `r` inputs, registers its `dataout`, and returns a one-cycle acknowledge to the winning requester. Range-checks every address against the memory depth, so an out-of-range access never reaches the array.

## Interface
Parameters:
- `DEPTH`, 256: memory size in bytes.
- `WORD_BYTES`, 8: bytes per access; the last legal start address is `DEPTH-WORD_BYTES` (248).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `p0_req`, `p1_req`  in  1  access request; held high with fields stable until the matching ack.
- `p0_we`, `p1_we`  in  1  1 = store, 0 = load.
- `p0_adr`, `p1_adr`  in  64  byte address.
- `p0_wdata`, `p1_wdata`  in  64  store data.
- `p0_ack`, `p1_ack`  out  1  one-cycle completion pulse.
- `p0_err`, `p1_err`  out  1  valid with ack; 1 = address out of range.
- `p0_rdata`, `p1_rdata`  out  64  load data; valid with ack.
- `mem_adr`  out  64  to memory `adr`.
- `mem_datain`  out  64  to memory `datain`.
- `mem_w`  out  1  to memory `w`.
- `mem_r`  out  1  to memory `r`.
- `mem_dataout`  in  64  from memory `dataout`; high-Z when `mem_r`=0.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any `req` is high, the arbiter picks a winner.
  - Latch the winner's id, `we`, `adr` and `wdata` into registers; compute `err` = (`adr[63:8]`≠0) or (`adr[7:0]` > `DEPTH-WORD_BYTES`).
  - Go to ACCESS. With no request, stay in IDLE.
- ACCESS (one cycle):
  - `mem_adr`/`mem_datain` come from the latched registers.
  - `mem_w` = `we & ~err`; `mem_r` = `~we & ~err`.
  - At the closing edge, the memory commits a store, or `mem_dataout` is captured into `rdata_q` (zero if `err` or a store).
  - Go to RESP.
- RESP (one cycle):
  - Assert the winner's `ack` with `err` and `rdata_q`; the other port's ack, err and rdata stay 0.
  - Update the last-grant pointer; go to IDLE.
- `mem_w` and `mem_r` are 0 outside ACCESS. `mem_adr` and `mem_datain` hold the latched values at all times.
- Misaligned in-range addresses (e.g. 3) are legal; byte order is little-endian, as the memory defines it.
- Requesters must not drop `req` before ack. After ack, a requester may keep `req` high for a new access.

## Timing
- Reset values: FSM=IDLE, all acks/errs 0, all rdata 0, `mem_w`=`mem_r`=0, `mem_adr`=`mem_datain`=0, last-grant pointer=1 (so port 0 wins the first tie).
- Latency: request sampled at edge N → ACCESS in cycle N+1 → ack high in cycle N+2 → IDLE in cycle N+3. Throughput is one access per 3 cycles.
- Simultaneous requests in IDLE: the winner is decided by the arbitration policy (Configuration). The loser stays pending and wins the next IDLE if still requesting.
- Reset asserted mid-operation: all outputs clear immediately (asynchronously), and no ack is issued.
  - If `rst_n` falls during ACCESS, `mem_w` drops before the edge, so no partial write occurs.
  - Memory contents are not reset.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. On a tie, the port not granted last wins; the pointer updates in RESP.
- Undefined: fixed priority; port 0 always wins ties. The pointer register is omitted.

## Structure
- Package `dmem_arb_pkg`:
  - FSM state enum (IDLE/ACCESS/RESP).
  - `NUM_PORTS`=2.
  - `DEPTH`/`WORD_BYTES` defaults.
  - Range-check function.
- Sub-module `rr_arbiter2`: 2-way grant logic with last-grant pointer; fixed-priority under the macro-off build.

## Test plan
- Reset, then p0 store `adr`=16, `wdata`=0x1122334455667788. Expected: `mem_w` high one cycle, `p0_ack` 2 cycles after request, `p0_err`=0.
- p1 load `adr`=16 after the previous test. Expected: `p1_rdata`=0x1122334455667788, `p1_ack` pulse, `p0_ack`=0 throughout.
- p0 and p1 both request loads continuously from reset. Expected with RR: grants alternate p0,p1,p0,p1. Expected without RR: p0 only while it requests.
- p0 load `adr`=249. Expected: `mem_r` stays 0, `p0_err`=1, `p0_rdata`=0. Same for `adr`=0x100.
- Initialized memory, p1 load `adr`=3. Expected: `p1_rdata`=0x0A09080706050403.
- `rst_n` pulsed low during ACCESS of a store to `adr`=0. Expected: no ack, outputs zero immediately, memory bytes 0–7 unchanged.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types, sizes and the address range check.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin tie-break).
package dmem_arb_pkg;

  localparam int NUM_PORTS      = 2;
  localparam int DEPTH_DEF      = 256;
  localparam int WORD_BYTES_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // A word access must fit entirely inside the array.
  function automatic logic adr_oob(
    input logic [63:0] adr,
    input int unsigned depth,
    input int unsigned wb
  );
    logic [63:0] last;
    last = 64'(depth - wb);
    return adr > last;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// rr_arbiter2: two-way grant with a last-grant pointer.
// DMEM_ARB_RR_EN selects round-robin; otherwise port 0 wins ties.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic       gnt_vld,
  output logic       gnt_id
);

`ifdef DMEM_ARB_RR_EN
  logic last_q;
  logic last_d;

  // Pointer follows the port that completed.
  always_comb begin
    last_d = last_q;
    if (upd) last_d = upd_id;
  end

  // Pointer starts at 1 so port 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

  // On a tie the port not granted last wins.
  always_comb begin
    gnt_vld = |req;
    gnt_id  = 1'b0;
    unique case (1'b1)
      (req == 2'b11): gnt_id = ~last_q;
      req[1]:         gnt_id = 1'b1;
      default:        gnt_id = 1'b0;
    endcase
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, upd, upd_id};

  // Port 0 always has priority.
  always_comb begin
    gnt_vld = |req;
    gnt_id  = req[1] & ~req[0];
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: sequences one 64-bit access at a time for two ports.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin tie-break).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int WORD_BYTES = WORD_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic        p0_we,
  input  logic        p1_we,
  input  logic [63:0] p0_adr,
  input  logic [63:0] p1_adr,
  input  logic [63:0] p0_wdata,
  input  logic [63:0] p1_wdata,
  output logic        p0_ack,
  output logic        p1_ack,
  output logic        p0_err,
  output logic        p1_err,
  output logic [63:0] p0_rdata,
  output logic [63:0] p1_rdata,
  output logic [63:0] mem_adr,
  output logic [63:0] mem_datain,
  output logic        mem_w,
  output logic        mem_r,
  input  logic [63:0] mem_dataout
);

  state_e      state_q, state_d;
  logic        id_q, id_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [63:0] adr_q, adr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        mem_w_q, mem_w_d;
  logic        mem_r_q, mem_r_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  perr_q, perr_d;
  logic [63:0] rd0_q, rd0_d;
  logic [63:0] rd1_q, rd1_d;

  logic        gnt_vld;
  logic        gnt_id;
  logic        upd;
  logic        sel_we;
  logic [63:0] sel_adr;
  logic [63:0] sel_wdata;
  logic        sel_err;
  logic [63:0] rd;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({p1_req, p0_req}),
    .upd     (upd),
    .upd_id  (id_q),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  // Winner's request fields and its range check.
  always_comb begin
    sel_we    = gnt_id ? p1_we    : p0_we;
    sel_adr   = gnt_id ? p1_adr   : p0_adr;
    sel_wdata = gnt_id ? p1_wdata : p0_wdata;
    sel_err   = adr_oob(sel_adr, DEPTH, WORD_BYTES);
    rd        = mem_r_q ? mem_dataout : 64'd0;
  end

  // Next-state and next-output logic for the access sequence.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    we_d    = we_q;
    err_d   = err_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    mem_w_d = 1'b0;
    mem_r_d = 1'b0;
    ack_d   = 2'b00;
    perr_d  = 2'b00;
    rd0_d   = 64'd0;
    rd1_d   = 64'd0;
    upd     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          id_d    = gnt_id;
          we_d    = sel_we;
          adr_d   = sel_adr;
          wdata_d = sel_wdata;
          err_d   = sel_err;
          mem_w_d = sel_we & ~sel_err;
          mem_r_d = ~sel_we & ~sel_err;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ack_d[id_q]  = 1'b1;
        perr_d[id_q] = err_q;
        if (id_q) rd1_d = rd;
        else      rd0_d = rd;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        upd     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset clears strobes at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      adr_q   <= 64'd0;
      wdata_q <= 64'd0;
      mem_w_q <= 1'b0;
      mem_r_q <= 1'b0;
      ack_q   <= 2'b00;
      perr_q  <= 2'b00;
      rd0_q   <= 64'd0;
      rd1_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      we_q    <= we_d;
      err_q   <= err_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      mem_w_q <= mem_w_d;
      mem_r_q <= mem_r_d;
      ack_q   <= ack_d;
      perr_q  <= perr_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign mem_adr    = adr_q;
  assign mem_datain = wdata_q;
  assign mem_w      = mem_w_q;
  assign mem_r      = mem_r_q;
  assign p0_ack     = ack_q[0];
  assign p1_ack     = ack_q[1];
  assign p0_err     = perr_q[0];
  assign p1_err     = perr_q[1];
  assign p0_rdata   = rd0_q;
  assign p1_rdata   = rd1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-array memory model.
// Build with DMEM_ARB_RR_EN defined to expect round-robin grants.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p1_req;
  logic        p0_we, p1_we;
  logic [63:0] p0_adr, p1_adr;
  logic [63:0] p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack;
  logic        p0_err, p1_err;
  logic [63:0] p0_rdata, p1_rdata;
  logic [63:0] mem_adr, mem_datain;
  logic        mem_w, mem_r;
  logic [63:0] mem_dataout;

  logic [7:0]  mem [256];

  int n_checks;
  int n_errors;

  dmem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .p0_req      (p0_req),
    .p1_req      (p1_req),
    .p0_we       (p0_we),
    .p1_we       (p1_we),
    .p0_adr      (p0_adr),
    .p1_adr      (p1_adr),
    .p0_wdata    (p0_wdata),
    .p1_wdata    (p1_wdata),
    .p0_ack      (p0_ack),
    .p1_ack      (p1_ack),
    .p0_err      (p0_err),
    .p1_err      (p1_err),
    .p0_rdata    (p0_rdata),
    .p1_rdata    (p1_rdata),
    .mem_adr     (mem_adr),
    .mem_datain  (mem_datain),
    .mem_w       (mem_w),
    .mem_r       (mem_r),
    .mem_dataout (mem_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: junk when not reading, so ungated capture shows up.
  always_comb begin
    mem_dataout = 64'hBAD0_BAD0_BAD0_BAD0;
    if (mem_r) begin
      for (int i = 0; i < 8; i++)
        mem_dataout[i*8 +: 8] = mem[8'(mem_adr[7:0] + 8'(i))];
    end
  end

  always @(posedge clk) begin
    if (mem_w) begin
      for (int i = 0; i < 8; i++)
        mem[8'(mem_adr[7:0] + 8'(i))] <= mem_datain[i*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input int a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = mem[(a + i) % 256];
    return w;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int port, input logic v, input logic we,
                         input logic [63:0] adr, input logic [63:0] wd);
    if (port == 0) begin
      p0_req = v; p0_we = we; p0_adr = adr; p0_wdata = wd;
    end else begin
      p1_req = v; p1_we = we; p1_adr = adr; p1_wdata = wd;
    end
  endtask

  // One access; latency counted in clock edges from the sampling edge.
  task automatic access(input int port, input logic we,
                        input logic [63:0] adr, input logic [63:0] wd,
                        output int lat, output logic err,
                        output logic [63:0] rd, output int nw,
                        output int nr, output int oth);
    logic own, other;
    lat = -1; err = 1'b0; rd = '0; nw = 0; nr = 0; oth = 0;
    @(negedge clk);
    set_req(port, 1'b1, we, adr, wd);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      own   = (port == 0) ? p0_ack : p1_ack;
      other = (port == 0) ? p1_ack : p0_ack;
      nw += int'(mem_w);
      nr += int'(mem_r);
      oth += int'(other);
      if (own) begin
        lat = k;
        err = (port == 0) ? p0_err : p1_err;
        rd  = (port == 0) ? p0_rdata : p1_rdata;
        break;
      end
    end
    set_req(port, 1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  int          lat, nw, nr, oth;
  logic        err;
  logic [63:0] rd;
  int          g [4];
  int          ng;
  int          seen;

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
    set_req(1, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    chk("rst_p0_ack", 64'(p0_ack), 64'd0);
    chk("rst_p1_ack", 64'(p1_ack), 64'd0);
    chk("rst_errs", 64'({p0_err, p1_err}), 64'd0);
    chk("rst_p0_rdata", p0_rdata, 64'd0);
    chk("rst_p1_rdata", p1_rdata, 64'd0);
    chk("rst_mem_wr", 64'({mem_w, mem_r}), 64'd0);
    chk("rst_mem_adr", mem_adr, 64'd0);
    chk("rst_mem_datain", mem_datain, 64'd0);
    rst_n = 1'b1;

    // p0 store to 16
    access(0, 1'b1, 64'd16, 64'h1122334455667788, lat, err, rd, nw, nr, oth);
    chk("st_lat", 64'(lat), 64'd2);
    chk("st_err", 64'(err), 64'd0);
    chk("st_w_cycles", 64'(nw), 64'd1);
    chk("st_r_cycles", 64'(nr), 64'd0);
    chk("st_mem", mem_word(16), 64'h1122334455667788);

    // p1 load back from 16
    access(1, 1'b0, 64'd16, 64'd0, lat, err, rd, nw, nr, oth);
    chk("ld_lat", 64'(lat), 64'd2);
    chk("ld_rdata", rd, 64'h1122334455667788);
    chk("ld_err", 64'(err), 64'd0);
    chk("ld_p0_ack", 64'(oth), 64'd0);
    chk("ld_r_cycles", 64'(nr), 64'd1);

    // misaligned p1 load at 3
    access(1, 1'b0, 64'd3, 64'd0, lat, err, rd, nw, nr, oth);
    chk("mis_rdata", rd, 64'h0A09080706050403);

    // last legal start address
    access(0, 1'b0, 64'd248, 64'd0, lat, err, rd, nw, nr, oth);
    chk("b248_err", 64'(err), 64'd0);
    chk("b248_rdata", rd, 64'hFFFEFDFCFBFAF9F8);

    // out of range loads
    access(0, 1'b0, 64'd249, 64'd0, lat, err, rd, nw, nr, oth);
    chk("o249_lat", 64'(lat), 64'd2);
    chk("o249_err", 64'(err), 64'd1);
    chk("o249_rdata", rd, 64'd0);
    chk("o249_r_cycles", 64'(nr), 64'd0);
    access(0, 1'b0, 64'h100, 64'd0, lat, err, rd, nw, nr, oth);
    chk("o100_err", 64'(err), 64'd1);
    chk("o100_rdata", rd, 64'd0);
    chk("o100_r_cycles", 64'(nr), 64'd0);

    // out of range store must not write
    access(1, 1'b1, 64'h1_0000_0010, 64'hDEAD, lat, err, rd, nw, nr, oth);
    chk("ost_err", 64'(err), 64'd1);
    chk("ost_w_cycles", 64'(nw), 64'd0);

    // reset during ACCESS of a store to 0
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #2;
    chk("mid_w_before", 64'(mem_w), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_w_after", 64'(mem_w), 64'd0);
    chk("mid_datain", mem_datain, 64'd0);
    chk("mid_acks", 64'({p0_ack, p1_ack}), 64'd0);
    set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      seen += int'(p0_ack | p1_ack);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      seen += int'(p0_ack | p1_ack);
    end
    chk("mid_no_ack", 64'(seen), 64'd0);
    chk("mid_mem", mem_word(0), 64'h0706050403020100);

    // both ports loading continuously from reset
    do_reset();
    set_req(0, 1'b1, 1'b0, 64'd0, 64'd0);
    set_req(1, 1'b1, 1'b0, 64'd8, 64'd0);
    ng = 0;
    seen = 0;
    for (int k = 0; k < 20 && ng < 4; k++) begin
      @(negedge clk);
      seen += int'(p0_ack & p1_ack);
      if (p0_ack) begin
        g[ng] = 0; ng++;
      end else if (p1_ack) begin
        g[ng] = 1; ng++;
        chk("cont_p1_rdata", p1_rdata, 64'h0F0E0D0C0B0A0908);
      end
    end
    set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
    set_req(1, 1'b0, 1'b0, 64'd0, 64'd0);
    chk("cont_grants", 64'(ng), 64'd4);
    chk("cont_both_ack", 64'(seen), 64'd0);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      chk($sformatf("cont_g%0d", i), 64'(g[i]), 64'(i % 2));
`else
      chk($sformatf("cont_g%0d", i), 64'(g[i]), 64'd0);
`endif
    end
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
